ysyx_22041071_mem_stage: RTL and testbench
==========================================

YSYX_22041071_MEM_STAGE -- requirements
Module: ysyx_22041071_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, width of PC and data-memory address.
REQ-002 SHALL have parameter DATA_W, default 64, width of register/memory data.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- valid5  in  1  upstream (EX) holds a valid instruction.
- ready5  out  1  this stage can accept from EX this cycle.
- PC5  in  ADDR_W  instruction PC.
- Ins4  in  32  instruction word.
- reg_w_en3  in  1  instruction writes rd.
- rdest2  in  5  destination register index.
- alu_res  in  DATA_W  ALU result; effective address for loads/stores.
- st_data  in  DATA_W  store data (rs2).
- mem_rd  in  1  instruction is a load.
- mem_wr  in  1  instruction is a store.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 double.
- mem_uns  in  1  load is zero-extended.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  ADDR_W  {alu_res[ADDR_W-1:3],3'b000}.
- dmem_wdata  out  DATA_W  st_data shifted left by 8*alu_res[2:0].
- dmem_wmask  out  8  byte enables, size mask shifted left by alu_res[2:0].
- dmem_ack  in  1  request complete; rdata valid same cycle.
- dmem_rdata  in  DATA_W  aligned 8-byte read data.
- valid6  out  1  result valid toward WB.
- ready6  in  1  WB accepts.
- PC6, Ins5, reg_w_en4, rdest3  out  ADDR_W/32/1/5  registered copies of the upstream fields.
- WB_data1  out  DATA_W  load result or alu_res.

Function
REQ-004 SHALL implement FSM states IDLE, MEM, HOLD; single-entry buffer.
REQ-005 SHALL assert ready5 = (state==IDLE) | (state==HOLD & ready6).
REQ-006 SHALL accept when valid5 & ready5: latch all upstream fields and access controls; non-memory op -> HOLD, memory op (mem_rd|mem_wr) -> MEM.
REQ-007 In MEM, SHALL drive dmem_req=1, with addr/wdata/wmask/we constant until dmem_ack; on ack -> HOLD.
REQ-008 SHALL treat mem_rd & mem_wr both set as a store.
REQ-009 SHALL drive dmem_req=0, dmem_we=0, dmem_wmask=0 outside MEM.
REQ-010 Load data: rdata >> 8*addr[2:0], take low 1/2/4/8 bytes, sign-extend unless mem_uns; captured into WB_data1 on ack.
REQ-011 Non-load ops (incl. stores) SHALL set WB_data1 = alu_res.
REQ-012 valid6 = (state==HOLD); outputs SHALL stay stable while valid6 & !ready6.
REQ-013 In HOLD with ready6: new accept -> IDLE-equivalent reload (HOLD or MEM); no accept -> IDLE.
REQ-014 Latency: non-memory op accepted at cycle N -> valid6 at N+1; memory op -> dmem_req at N+1, valid6 the cycle after ack.
REQ-015 Bytes of wmask shifted past bit 7 (misaligned crossing 8 bytes) SHALL be dropped; no exception generated.
REQ-016 A stalled WB (ready6=0) SHALL NOT block an outstanding dmem request from completing.

Reset
REQ-017 While reset=0: state=IDLE, valid6=0, dmem_req=0, dmem_we=0, dmem_wmask=0, PC6=0, Ins5=0, reg_w_en4=0, rdest3=0, WB_data1=0.
REQ-018 Reset during MEM SHALL drop dmem_req in the same cycle and discard the access; a late dmem_ack after release SHALL be ignored in IDLE.

Verification
REQ-019 ALU op alu_res=0x1234, rdest2=5, ready6=1 -> next cycle valid6=1, WB_data1=0x1234, rdest3=5, dmem_req never asserted.
REQ-020 lb addr=0x1003, mem_uns=0, rdata=0x00000000_80000000 shifted so byte3=0x80, ack after 3 cycles -> dmem_req high 3 cycles, dmem_addr=0x1000, WB_data1=0xFFFF_FFFF_FFFF_FF80.
REQ-021 sh addr=0x2006, st_data=0xBEEF, ack same cycle -> dmem_we=1, wmask=0xC0, wdata[63:48]=0xBEEF, WB_data1=0x2006.
REQ-022 Back-to-back ALU ops with ready6=0 for 4 cycles -> valid6 held, outputs stable, ready5=0; release ready6 -> second op accepted that cycle, no loss or duplication.
REQ-023 Assert reset mid-load (MEM) then ack arrives after release -> all outputs zero, state IDLE, ack ignored, next instruction processed normally.
REQ-024 ld addr=0x3000, mem_uns=1, rdata=0x8000_0000_0000_0001 -> WB_data1=0x8000_0000_0000_0001 (no extension change).

Source files
------------

// File: rtl/ysyx_22041071_mem_stage.sv
// ysyx_22041071_mem_stage
// Memory pipeline stage. It holds one instruction taken from EX, performs
// the optional data-memory access, and presents the result to WB.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   valid5 / ready5     handshake with EX
//   PC5, Ins4, reg_w_en3, rdest2, alu_res, st_data,
//   mem_rd, mem_wr, mem_size, mem_uns
//                       instruction fields and access controls from EX
//   dmem_*              data-memory request/response (aligned 8-byte port)
//   valid6 / ready6     handshake with WB
//   PC6, Ins5, reg_w_en4, rdest3, WB_data1
//                       registered instruction fields and result toward WB
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | buffer empty, ready for EX
// MEM   | buffer holds a load/store, dmem request outstanding
// HOLD  | buffer holds a finished result, valid6 asserted
module ysyx_22041071_mem_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid5,
  output logic              ready5,
  input  logic [ADDR_W-1:0] PC5,
  input  logic [31:0]       Ins4,
  input  logic              reg_w_en3,
  input  logic [4:0]        rdest2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] st_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic              mem_uns,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              valid6,
  input  logic              ready6,
  output logic [ADDR_W-1:0] PC6,
  output logic [31:0]       Ins5,
  output logic              reg_w_en4,
  output logic [4:0]        rdest3,
  output logic [DATA_W-1:0] WB_data1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ins_q;
  logic              wen_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q;
  logic              ld_q;
  logic              st_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wb_q;

  logic              accept;
  logic [7:0]        size_mask;
  logic [14:0]       mask_wide;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] ld_val;

  always_comb begin
    state_d    = state_q;
    ready5     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_wmask = 8'h00;
    valid6     = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: ready5 = 1'b1;
      MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = st_q;
        dmem_wmask = mask_wide[7:0];
        if (dmem_ack) state_d = HOLD;
      end
      HOLD: begin
        valid6 = 1'b1;
        ready5 = ready6;
        if (ready6) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = valid5 & ready5;
    if (accept) state_d = (mem_rd | mem_wr) ? MEM : HOLD;
  end

  always_comb begin
    size_mask = 8'h01;
    case (size_q)
      2'b00: size_mask = 8'h01;
      2'b01: size_mask = 8'h03;
      2'b10: size_mask = 8'h0F;
      2'b11: size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
  end

  // Lanes pushed past byte 7 fall off the top of the 8-bit mask.
  assign mask_wide  = {7'b0, size_mask} << addr_q[2:0];
  assign dmem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_wdata = sdata_q << {addr_q[2:0], 3'b000};

  assign rsh = dmem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_val = rsh;
    case (size_q)
      2'b00: ld_val = {{(DATA_W-8){~uns_q & rsh[7]}}, rsh[7:0]};
      2'b01: ld_val = {{(DATA_W-16){~uns_q & rsh[15]}}, rsh[15:0]};
      2'b10: ld_val = {{(DATA_W-32){~uns_q & rsh[31]}}, rsh[31:0]};
      2'b11: ld_val = rsh;
      default: ld_val = rsh;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ins_q   <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q    <= PC5;
        ins_q   <= Ins4;
        wen_q   <= reg_w_en3;
        rd_q    <= rdest2;
        addr_q  <= alu_res;
        sdata_q <= st_data;
        // Both rd and wr set is treated as a store.
        ld_q    <= mem_rd & ~mem_wr;
        st_q    <= mem_wr;
        size_q  <= mem_size;
        uns_q   <= mem_uns;
        wb_q    <= alu_res;
      end else if (state_q == MEM && dmem_ack && ld_q) begin
        wb_q <= ld_val;
      end
    end
  end

  assign PC6       = pc_q;
  assign Ins5      = ins_q;
  assign reg_w_en4 = wen_q;
  assign rdest3    = rd_q;
  assign WB_data1  = wb_q;

endmodule

// File: tb/tb_ysyx_22041071_mem_stage.sv
module tb_ysyx_22041071_mem_stage;

  logic        clk;
  logic        reset;
  logic        valid5;
  logic        ready5;
  logic [63:0] PC5;
  logic [31:0] Ins4;
  logic        reg_w_en3;
  logic [4:0]  rdest2;
  logic [63:0] alu_res;
  logic [63:0] st_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_uns;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        valid6;
  logic        ready6;
  logic [63:0] PC6;
  logic [31:0] Ins5;
  logic        reg_w_en4;
  logic [4:0]  rdest3;
  logic [63:0] WB_data1;

  int errors = 0;
  int checks = 0;

  ysyx_22041071_mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .valid5(valid5), .ready5(ready5),
    .PC5(PC5), .Ins4(Ins4), .reg_w_en3(reg_w_en3), .rdest2(rdest2),
    .alu_res(alu_res), .st_data(st_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_uns(mem_uns),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid6(valid6), .ready6(ready6),
    .PC6(PC6), .Ins5(Ins5), .reg_w_en4(reg_w_en4), .rdest3(rdest3),
    .WB_data1(WB_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } req_t;

  // Memory contents as seen by the bench: a fixed function of the aligned address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] * 32'h9E3779B1, a[31:0] ^ 32'hC3D2E1F0};
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                           input int sz, input logic uns);
    int nb;
    logic [127:0] v, m;
    logic [63:0] r, m64;
    nb  = 1 << sz;
    v   = {64'b0, rdata} >> (8 * off);
    m   = (128'd1 << (8 * nb)) - 128'd1;
    v   = v & m;
    r   = v[63:0];
    m64 = m[63:0];
    if (!uns && r[8*nb-1]) r = r | ~m64;
    return r;
  endfunction

  function automatic logic [7:0] ref_wmask(input int off, input int sz);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < (1 << sz); i++)
      if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] sd, input int off);
    logic [63:0] w;
    w = 64'h0;
    for (int i = 0; i < 8; i++)
      if (off + i < 8) w[8*(off+i) +: 8] = sd[8*i +: 8];
    return w;
  endfunction

  task automatic inputs_idle();
    valid5 = 0; PC5 = 0; Ins4 = 0; reg_w_en3 = 0; rdest2 = 0;
    alu_res = 0; st_data = 0; mem_rd = 0; mem_wr = 0; mem_size = 0; mem_uns = 0;
    dmem_ack = 0; dmem_rdata = 0; ready6 = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    inputs_idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (valid6 !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_wmask !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: valid6=%b req=%b we=%b wmask=%h, want 0 0 0 00",
               valid6, dmem_req, dmem_we, dmem_wmask);
    end
    checks++;
    if (PC6 !== 64'h0 || Ins5 !== 32'h0 || reg_w_en4 !== 1'b0 || rdest3 !== 5'h0 || WB_data1 !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: PC6=%h Ins5=%h wen=%b rd=%0d wb=%h, want all zero",
               PC6, Ins5, reg_w_en4, rdest3, WB_data1);
    end
    checks++;
    if (ready5 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready5: got %b want 1", ready5);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    valid5 = 1; PC5 = 64'h8000_0000; Ins4 = 32'h0000_0293; reg_w_en3 = 1;
    alu_res = 64'h1234; rdest2 = 5; ready6 = 1;
    #1;
    checks++;
    if (ready5 !== 1'b1) begin errors++; $display("FAIL alu_ready5: got %b want 1", ready5); end
    @(negedge clk);
    valid5 = 0;
    #1;
    checks++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'h1234 || rdest3 !== 5'd5 || PC6 !== 64'h8000_0000 || reg_w_en4 !== 1'b1) begin
      errors++;
      $display("FAIL alu_result: valid6=%b wb=%h rd=%0d pc=%h wen=%b, want 1 1234 5 80000000 1",
               valid6, WB_data1, rdest3, PC6, reg_w_en4);
    end
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_noreq: req=%b want 0", dmem_req); end
    @(negedge clk);
    #1;
    checks++;
    if (valid6 !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_drain: valid6=%b req=%b want 0 0", valid6, dmem_req);
    end
    inputs_idle();
  endtask

  task automatic test_lb();
    int cnt;
    cnt = 0;
    @(negedge clk);
    valid5 = 1; alu_res = 64'h1003; mem_rd = 1; mem_size = 2'b00; mem_uns = 0;
    rdest2 = 7; reg_w_en3 = 1; ready6 = 1;
    @(negedge clk);
    valid5 = 0; mem_rd = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dmem_req) cnt++;
      if (i == 0) begin
        checks++;
        if (dmem_addr !== 64'h1000 || dmem_we !== 1'b0 || dmem_wmask !== 8'h08) begin
          errors++;
          $display("FAIL lb_req: addr=%h we=%b wmask=%h want 1000 0 08", dmem_addr, dmem_we, dmem_wmask);
        end
      end
      if (i == 2) begin dmem_ack = 1; dmem_rdata = 64'h0000_0000_8000_0000; end
      else dmem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    dmem_ack = 0;
    #1;
    checks++;
    if (cnt != 3) begin errors++; $display("FAIL lb_req_cycles: got %0d want 3", cnt); end
    checks++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'hFFFF_FFFF_FFFF_FF80 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lb_result: valid6=%b wb=%h req=%b want 1 ffffffffffffff80 0", valid6, WB_data1, dmem_req);
    end
    @(negedge clk);
    inputs_idle();
  endtask

  task automatic test_sh();
    @(negedge clk);
    valid5 = 1; alu_res = 64'h2006; st_data = 64'hBEEF; mem_wr = 1; mem_size = 2'b01; ready6 = 1;
    @(negedge clk);
    valid5 = 0; mem_wr = 0;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wmask !== 8'hC0 || dmem_wdata[63:48] !== 16'hBEEF) begin
      errors++;
      $display("FAIL sh_req: req=%b we=%b wmask=%h wdata=%h want 1 1 c0 beef.. ", dmem_req, dmem_we, dmem_wmask, dmem_wdata);
    end
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    #1;
    checks++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'h2006 || dmem_we !== 1'b0 || dmem_wmask !== 8'h00 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sh_result: valid6=%b wb=%h we=%b wmask=%h req=%b want 1 2006 0 00 0",
               valid6, WB_data1, dmem_we, dmem_wmask, dmem_req);
    end
    @(negedge clk);
    inputs_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ready6 = 0; valid5 = 1; alu_res = 64'h111; rdest2 = 1; PC5 = 64'h100;
    @(negedge clk);
    alu_res = 64'h222; rdest2 = 2; PC5 = 64'h104;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (valid6 !== 1'b1 || ready5 !== 1'b0 || WB_data1 !== 64'h111 || rdest3 !== 5'd1 || PC6 !== 64'h100) begin
        errors++;
        $display("FAIL b2b_stall: cyc=%0d valid6=%b ready5=%b wb=%h rd=%0d pc=%h want 1 0 111 1 100",
                 i, valid6, ready5, WB_data1, rdest3, PC6);
      end
      @(negedge clk);
    end
    ready6 = 1;
    #1;
    checks++;
    if (ready5 !== 1'b1) begin errors++; $display("FAIL b2b_release_ready5: got %b want 1", ready5); end
    @(negedge clk);
    valid5 = 0;
    #1;
    checks++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'h222 || rdest3 !== 5'd2 || PC6 !== 64'h104) begin
      errors++;
      $display("FAIL b2b_second: valid6=%b wb=%h rd=%0d pc=%h want 1 222 2 104", valid6, WB_data1, rdest3, PC6);
    end
    @(negedge clk);
    #1;
    checks++;
    if (valid6 !== 1'b0) begin errors++; $display("FAIL b2b_nodup: valid6=%b want 0", valid6); end
    inputs_idle();
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    valid5 = 1; alu_res = 64'h4004; mem_rd = 1; mem_size = 2'b10; PC5 = 64'h200; rdest2 = 9; reg_w_en3 = 1;
    @(negedge clk);
    valid5 = 0; mem_rd = 0;
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rml_req: got %b want 1", dmem_req); end
    #1;
    reset = 0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || valid6 !== 1'b0 || PC6 !== 64'h0 || WB_data1 !== 64'h0) begin
      errors++;
      $display("FAIL rml_async: req=%b valid6=%b pc=%h wb=%h want all zero", dmem_req, valid6, PC6, WB_data1);
    end
    @(negedge clk);
    reset = 1;
    dmem_ack = 1; dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    dmem_ack = 0;
    #1;
    checks++;
    if (valid6 !== 1'b0 || dmem_req !== 1'b0 || WB_data1 !== 64'h0 || rdest3 !== 5'd0 || ready5 !== 1'b1) begin
      errors++;
      $display("FAIL rml_ignore_ack: valid6=%b req=%b wb=%h rd=%0d ready5=%b want 0 0 0 0 1",
               valid6, dmem_req, WB_data1, rdest3, ready5);
    end
    valid5 = 1; alu_res = 64'h5555; rdest2 = 3; ready6 = 1;
    @(negedge clk);
    valid5 = 0;
    #1;
    checks++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'h5555 || rdest3 !== 5'd3) begin
      errors++;
      $display("FAIL rml_next: valid6=%b wb=%h rd=%0d want 1 5555 3", valid6, WB_data1, rdest3);
    end
    @(negedge clk);
    inputs_idle();
  endtask

  task automatic test_ld_uns();
    @(negedge clk);
    valid5 = 1; alu_res = 64'h3000; mem_rd = 1; mem_size = 2'b11; mem_uns = 1; ready6 = 1;
    @(negedge clk);
    valid5 = 0; mem_rd = 0;
    #1;
    checks++;
    if (dmem_addr !== 64'h3000 || dmem_wmask !== 8'hFF || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL ld_req: addr=%h wmask=%h we=%b want 3000 ff 0", dmem_addr, dmem_wmask, dmem_we);
    end
    dmem_ack = 1; dmem_rdata = 64'h8000_0000_0000_0001;
    @(negedge clk);
    dmem_ack = 0;
    #1;
    checks++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'h8000_0000_0000_0001) begin
      errors++;
      $display("FAIL ld_result: valid6=%b wb=%h want 1 8000000000000001", valid6, WB_data1);
    end
    @(negedge clk);
    inputs_idle();
  endtask

  task automatic test_random();
    localparam int N = 300;
    wb_t  q_wb[$];
    req_t q_req[$];
    wb_t  e, snap;
    req_t r, held;
    int   n_sent, n_done, cyc, delay, off, sz;
    logic outstanding, acc, prev_stall;
    n_sent = 0; n_done = 0; cyc = 0; delay = 0;
    outstanding = 0; acc = 0; prev_stall = 0;
    held = '{default: '0};
    snap = '{default: '0};
    while (n_done < N && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin valid5 = 0; acc = 0; end
      if (!valid5 && n_sent < N && $urandom_range(0, 3) != 0) begin
        int kind;
        kind      = $urandom_range(0, 2);
        PC5       = {32'h0, $urandom} & ~64'h3;
        Ins4      = $urandom;
        reg_w_en3 = 1'($urandom_range(0, 1));
        rdest2    = 5'($urandom_range(0, 31));
        alu_res   = {$urandom, $urandom};
        st_data   = {$urandom, $urandom};
        mem_size  = 2'($urandom_range(0, 3));
        mem_uns   = 1'($urandom_range(0, 1));
        mem_rd    = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
        mem_wr    = (kind == 2);
        valid5    = 1;
      end
      ready6 = ($urandom_range(0, 2) != 0);
      dmem_ack = 0;
      dmem_rdata = {$urandom, $urandom};
      if (prev_stall) begin
        checks++;
        if (PC6 !== snap.pc || Ins5 !== snap.ins || reg_w_en4 !== snap.wen || rdest3 !== snap.rd || WB_data1 !== snap.data || valid6 !== 1'b1) begin
          errors++;
          $display("FAIL rnd_stall_stable: cyc=%0d pc=%h wb=%h valid6=%b want pc=%h wb=%h valid6=1",
                   cyc, PC6, WB_data1, valid6, snap.pc, snap.data);
        end
      end
      if (dmem_req) begin
        if (!outstanding) begin
          outstanding = 1;
          delay = $urandom_range(0, 3);
          checks++;
          if (q_req.size() == 0) begin
            errors++;
            $display("FAIL rnd_req_unexpected: cyc=%0d addr=%h", cyc, dmem_addr);
            held = '{addr: dmem_addr, we: dmem_we, wmask: dmem_wmask, wdata: dmem_wdata};
          end else begin
            held = q_req.pop_front();
            if (dmem_addr !== held.addr || dmem_we !== held.we || dmem_wmask !== held.wmask || dmem_wdata !== held.wdata) begin
              errors++;
              $display("FAIL rnd_req: cyc=%0d addr=%h we=%b wm=%h wd=%h want %h %b %h %h", cyc,
                       dmem_addr, dmem_we, dmem_wmask, dmem_wdata, held.addr, held.we, held.wmask, held.wdata);
            end
          end
        end else begin
          checks++;
          if (dmem_addr !== held.addr || dmem_we !== held.we || dmem_wmask !== held.wmask || dmem_wdata !== held.wdata) begin
            errors++;
            $display("FAIL rnd_req_stable: cyc=%0d addr=%h wm=%h want %h %h", cyc, dmem_addr, dmem_wmask, held.addr, held.wmask);
          end
        end
        if (delay == 0) begin
          dmem_ack = 1;
          dmem_rdata = mem_word(dmem_addr);
          outstanding = 0;
        end else delay--;
      end
      #1;
      if (valid6 && ready6) begin
        checks++;
        if (q_wb.size() == 0) begin
          errors++;
          $display("FAIL rnd_wb_unexpected: cyc=%0d pc=%h", cyc, PC6);
        end else begin
          e = q_wb.pop_front();
          if (PC6 !== e.pc || Ins5 !== e.ins || reg_w_en4 !== e.wen || rdest3 !== e.rd || WB_data1 !== e.data) begin
            errors++;
            $display("FAIL rnd_wb: cyc=%0d pc=%h ins=%h wen=%b rd=%0d wb=%h want %h %h %b %0d %h", cyc,
                     PC6, Ins5, reg_w_en4, rdest3, WB_data1, e.pc, e.ins, e.wen, e.rd, e.data);
          end
        end
        n_done++;
      end
      if (valid5 && ready5) begin
        off = int'(alu_res[2:0]);
        sz  = int'(mem_size);
        e.pc = PC5; e.ins = Ins4; e.wen = reg_w_en3; e.rd = rdest2;
        if (mem_rd && !mem_wr)
          e.data = ref_load(mem_word(alu_res & ~64'h7), off, sz, mem_uns);
        else
          e.data = alu_res;
        q_wb.push_back(e);
        if (mem_rd || mem_wr) begin
          r.addr  = alu_res & ~64'h7;
          r.we    = mem_wr;
          r.wmask = ref_wmask(off, sz);
          r.wdata = ref_wdata(st_data, off);
          q_req.push_back(r);
        end
        n_sent++;
        acc = 1;
      end
      prev_stall = valid6 && !ready6;
      snap.pc = PC6; snap.ins = Ins5; snap.wen = reg_w_en4; snap.rd = rdest3; snap.data = WB_data1;
    end
    checks++;
    if (n_done != N) begin
      errors++;
      $display("FAIL rnd_complete: retired %0d of %0d within cycle budget", n_done, N);
    end
    inputs_idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_back_to_back();
    test_reset_mid_load();
    test_ld_uns();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
